// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard front-end.
// Scan-code set 2 prefix/control bytes and the decoder state encoding.
package ps2_pkg;

  localparam int KEY_IDX_W = 9;
  localparam int KEY_MAP_W = 1 << KEY_IDX_W;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_E1 = 8'hE1;

  localparam logic [7:0] IGN_AA = 8'hAA;
  localparam logic [7:0] IGN_FA = 8'hFA;
  localparam logic [7:0] IGN_FE = 8'hFE;
  localparam logic [7:0] IGN_EE = 8'hEE;
  localparam logic [7:0] IGN_00 = 8'h00;
  localparam logic [7:0] IGN_FF = 8'hFF;

  // Bytes that follow an E1 in the Pause sequence.
  localparam logic [2:0] SKIP_LOAD = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } dec_state_e;

  function automatic logic is_ignored(input logic [7:0] b);
    return (b == IGN_AA) || (b == IGN_FA) || (b == IGN_FE) ||
           (b == IGN_EE) || (b == IGN_00) || (b == IGN_FF);
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: pin synchronizers, falling-edge sampling,
// 11-bit framing with odd parity and an in-frame idle timeout.
module ps2_rx_frame #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [IDLE_W-1:0]      idle_q, idle_d;
  logic                   byte_valid_q, byte_valid_d;
  logic                   frame_err_q, frame_err_d;

  logic clk_s, data_s, fall;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_s;

  always_comb begin
    clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_prev_d   = clk_s;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    idle_d       = idle_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    // An edge in the timeout cycle takes priority, so the timeout is never seen.
    if (fall) begin
      idle_d = '0;
      if (bit_cnt_q == 4'd0) begin
        if (!data_s) bit_cnt_d = 4'd1;
      end else if (bit_cnt_q <= 4'd8) begin
        shift_d   = {data_s, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else if (bit_cnt_q == 4'd9) begin
        parity_d  = data_s;
        bit_cnt_d = 4'd10;
      end else begin
        bit_cnt_d = 4'd0;
        if (data_s && (^{shift_q, parity_q})) byte_valid_d = 1'b1;
        else                                  frame_err_d  = 1'b1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (idle_q == IDLE_W'(TIMEOUT_CYC)) begin
        bit_cnt_d   = 4'd0;
        idle_d      = '0;
        frame_err_d = 1'b1;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q   <= '1;
      data_sync_q  <= '1;
      clk_prev_q   <= 1'b1;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      idle_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      clk_prev_q   <= clk_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      idle_q       <= idle_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_byte    = shift_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// Scan-code set 2 decoder: turns received bytes into make/break events and
// keeps a pressed-key map indexed by {ext, code}.
//
// state      | meaning
// IDLE       | waiting for a code or prefix
// EXT        | E0 seen, next code is extended make
// BRK        | F0 seen, next code is a break
// EXT_BRK    | E0 F0 seen, next code is extended break
// SKIP       | inside the Pause sequence, dropping bytes
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  output logic [KEY_MAP_W-1:0] key_down,
  output logic [KEY_IDX_W-1:0] last_change,
  output logic                 been_ready,
  output logic                 frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  ps2_rx_frame #(
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(rx_valid),
    .frame_err (rx_err)
  );

  dec_state_e             state_q, state_d;
  logic [2:0]             skip_q, skip_d;
  logic [KEY_MAP_W-1:0]   key_down_q, key_down_d;
  logic [KEY_IDX_W-1:0]   last_change_q, last_change_d;
  logic                   been_ready_q, been_ready_d;
  logic                   is_ext;
  logic [KEY_IDX_W-1:0]   code_idx;

  assign is_ext   = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
  assign code_idx = {is_ext, rx_byte};

  always_comb begin
    state_d       = state_q;
    skip_d        = skip_q;
    key_down_d    = key_down_q;
    last_change_d = last_change_q;
    been_ready_d  = 1'b0;

    if (rx_err) begin
      state_d = ST_IDLE;
      skip_d  = 3'd0;
    end else if (rx_valid) begin
      // While skipping, every byte counts down, including the second E1 of Pause.
      if (state_q == ST_SKIP) begin
        skip_d = skip_q - 3'd1;
        if (skip_q == 3'd1) state_d = ST_IDLE;
      end else if (rx_byte == BYTE_E1) begin
        state_d = ST_SKIP;
        skip_d  = SKIP_LOAD;
      end else if (is_ignored(rx_byte)) begin
        state_d = state_q;
      end else if (rx_byte == BYTE_E0 && state_q == ST_IDLE) begin
        state_d = ST_EXT;
      end else if (rx_byte == BYTE_F0 && state_q == ST_IDLE) begin
        state_d = ST_BRK;
      end else if (rx_byte == BYTE_F0 && state_q == ST_EXT) begin
        state_d = ST_EXT_BRK;
      end else begin
        key_down_d[code_idx] = (state_q == ST_IDLE) || (state_q == ST_EXT);
        last_change_d        = code_idx;
        been_ready_d         = 1'b1;
        state_d              = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      skip_q        <= 3'd0;
      key_down_q    <= '0;
      last_change_q <= '0;
      been_ready_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      skip_q        <= skip_d;
      key_down_q    <= key_down_d;
      last_change_q <= last_change_d;
      been_ready_q  <= been_ready_d;
    end
  end

  assign key_down    = key_down_q;
  assign last_change = last_change_q;
  assign been_ready  = been_ready_q;
  assign frame_err   = rx_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-bangs PS/2 frames and checks the
// key map, event strobe, error strobe and their latencies.
module tb_ps2_key_decoder;

  localparam int TO = 200;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ps2_clk = 1'b1;
  logic         ps2_data = 1'b1;
  logic [511:0] key_down;
  logic [8:0]   last_change;
  logic         been_ready;
  logic         frame_err;

  ps2_key_decoder #(.SYNC_STAGES(2), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key_down   (key_down),
    .last_change(last_change),
    .been_ready (been_ready),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int br_cnt = 0, fe_cnt = 0, br_cyc = 0, fe_cyc = 0, stop_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (been_ready) begin br_cnt++; br_cyc = cyc; end
    if (frame_err)  begin fe_cnt++; fe_cyc = cyc; end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    tick(10);
    ps2_clk  = 1'b0;
    stop_cyc = cyc;
    tick(20);
    ps2_clk  = 1'b1;
    tick(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip = 1'b0,
                            input logic stop_val = 1'b1);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ par_flip);
    ps2_bit(stop_val);
    ps2_data = 1'b1;
    tick(30);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick(5);
    checks++; if (key_down !== 512'd0) begin errors++; $display("FAIL reset_key_down: got nonzero map, expected 0"); end
    checks++; if (last_change !== 9'h000) begin errors++; $display("FAIL reset_last_change: got %h expected 000", last_change); end
    checks++; if (been_ready !== 1'b0) begin errors++; $display("FAIL reset_been_ready: got %b expected 0", been_ready); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    rst = 1'b1;
    tick(5);
  endtask

  task automatic test_make_break;
    int br0;
    br0 = br_cnt;
    send_frame(8'h1C);
    checks++; if (br_cnt !== br0 + 1) begin errors++; $display("FAIL make_1c_count: got %0d pulses expected 1", br_cnt - br0); end
    checks++; if (br_cyc - stop_cyc !== 4) begin errors++; $display("FAIL make_1c_latency: got %0d cycles expected 4", br_cyc - stop_cyc); end
    checks++; if (key_down[9'h01C] !== 1'b1) begin errors++; $display("FAIL make_1c_bit: got %b expected 1", key_down[9'h01C]); end
    checks++; if (last_change !== 9'h01C) begin errors++; $display("FAIL make_1c_last: got %h expected 01c", last_change); end
    send_frame(8'hF0);
    send_frame(8'h1C);
    checks++; if (br_cnt !== br0 + 2) begin errors++; $display("FAIL break_1c_count: got %0d pulses expected 2", br_cnt - br0); end
    checks++; if (key_down[9'h01C] !== 1'b0) begin errors++; $display("FAIL break_1c_bit: got %b expected 0", key_down[9'h01C]); end
    checks++; if (last_change !== 9'h01C) begin errors++; $display("FAIL break_1c_last: got %h expected 01c", last_change); end
  endtask

  task automatic test_extended;
    int br0;
    br0 = br_cnt;
    send_frame(8'hE0);
    send_frame(8'h75);
    checks++; if (key_down[9'h175] !== 1'b1) begin errors++; $display("FAIL ext_make_bit: got %b expected 1", key_down[9'h175]); end
    checks++; if (key_down[9'h075] !== 1'b0) begin errors++; $display("FAIL ext_plain_bit: got %b expected 0", key_down[9'h075]); end
    checks++; if (last_change !== 9'h175) begin errors++; $display("FAIL ext_make_last: got %h expected 175", last_change); end
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    checks++; if (key_down[9'h175] !== 1'b0) begin errors++; $display("FAIL ext_break_bit: got %b expected 0", key_down[9'h175]); end
    checks++; if (last_change !== 9'h175) begin errors++; $display("FAIL ext_break_last: got %h expected 175", last_change); end
    checks++; if (br_cnt !== br0 + 2) begin errors++; $display("FAIL ext_count: got %0d pulses expected 2", br_cnt - br0); end
  endtask

  task automatic test_typematic;
    int br0;
    br0 = br_cnt;
    for (int i = 0; i < 3; i++) send_frame(8'h1C);
    checks++; if (br_cnt !== br0 + 3) begin errors++; $display("FAIL typematic_count: got %0d pulses expected 3", br_cnt - br0); end
    checks++; if (key_down !== (512'd1 << 28)) begin errors++; $display("FAIL typematic_map: bit 01c=%b, popcount=%0d expected only 01c", key_down[28], $countones(key_down)); end
    send_frame(8'hF0);
    send_frame(8'h1C);
    checks++; if (key_down !== 512'd0) begin errors++; $display("FAIL typematic_release: popcount=%0d expected 0", $countones(key_down)); end
  endtask

  task automatic test_ignore;
    int br0;
    br0 = br_cnt;
    send_frame(8'hAA);
    send_frame(8'hFA);
    send_frame(8'h00);
    checks++; if (br_cnt !== br0) begin errors++; $display("FAIL ignore_count: got %0d pulses expected 0", br_cnt - br0); end
    send_frame(8'hE0);
    send_frame(8'hFE);
    send_frame(8'h75);
    checks++; if (last_change !== 9'h175) begin errors++; $display("FAIL ignore_keeps_ext: got %h expected 175", last_change); end
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    checks++; if (key_down[9'h175] !== 1'b0) begin errors++; $display("FAIL ignore_release: got %b expected 0", key_down[9'h175]); end
  endtask

  task automatic test_break_unheld;
    int br0;
    br0 = br_cnt;
    send_frame(8'hF0);
    send_frame(8'h33);
    checks++; if (br_cnt !== br0 + 1) begin errors++; $display("FAIL unheld_count: got %0d pulses expected 1", br_cnt - br0); end
    checks++; if (last_change !== 9'h033) begin errors++; $display("FAIL unheld_last: got %h expected 033", last_change); end
    checks++; if (key_down[9'h033] !== 1'b0) begin errors++; $display("FAIL unheld_bit: got %b expected 0", key_down[9'h033]); end
  endtask

  task automatic test_parity;
    int br0, fe0;
    logic [511:0] kd_save;
    br0 = br_cnt; fe0 = fe_cnt; kd_save = key_down;
    send_frame(8'h29, 1'b1);
    checks++; if (fe_cnt !== fe0 + 1) begin errors++; $display("FAIL parity_err_count: got %0d pulses expected 1", fe_cnt - fe0); end
    checks++; if (fe_cyc - stop_cyc !== 3) begin errors++; $display("FAIL parity_err_latency: got %0d cycles expected 3", fe_cyc - stop_cyc); end
    checks++; if (br_cnt !== br0) begin errors++; $display("FAIL parity_no_event: got %0d pulses expected 0", br_cnt - br0); end
    checks++; if (key_down !== kd_save) begin errors++; $display("FAIL parity_map_kept: popcount=%0d expected %0d", $countones(key_down), $countones(kd_save)); end
    send_frame(8'h29);
    checks++; if (key_down[9'h029] !== 1'b1) begin errors++; $display("FAIL parity_good_29: got %b expected 1", key_down[9'h029]); end
    send_frame(8'hE0);
    send_frame(8'h75, 1'b1);
    send_frame(8'h75);
    checks++; if (last_change !== 9'h075) begin errors++; $display("FAIL parity_fsm_idle: got %h expected 075", last_change); end
    checks++; if (key_down[9'h175] !== 1'b0) begin errors++; $display("FAIL parity_no_ext: got %b expected 0", key_down[9'h175]); end
  endtask

  task automatic test_stop_err;
    int br0, fe0;
    br0 = br_cnt; fe0 = fe_cnt;
    send_frame(8'hF0);
    send_frame(8'h33, 1'b0, 1'b0);
    checks++; if (fe_cnt !== fe0 + 1) begin errors++; $display("FAIL stop_err_count: got %0d pulses expected 1", fe_cnt - fe0); end
    checks++; if (fe_cyc - stop_cyc !== 3) begin errors++; $display("FAIL stop_err_latency: got %0d cycles expected 3", fe_cyc - stop_cyc); end
    send_frame(8'h33);
    checks++; if (key_down[9'h033] !== 1'b1) begin errors++; $display("FAIL stop_err_fsm_idle: got %b expected 1", key_down[9'h033]); end
    checks++; if (br_cnt !== br0 + 1) begin errors++; $display("FAIL stop_err_events: got %0d pulses expected 1", br_cnt - br0); end
  endtask

  task automatic test_start_glitch;
    int fe0;
    fe0 = fe_cnt;
    ps2_bit(1'b1);
    send_frame(8'h4D);
    checks++; if (key_down[9'h04D] !== 1'b1) begin errors++; $display("FAIL start_glitch_bit: got %b expected 1", key_down[9'h04D]); end
    checks++; if (fe_cnt !== fe0) begin errors++; $display("FAIL start_glitch_err: got %0d pulses expected 0", fe_cnt - fe0); end
  endtask

  task automatic test_timeout;
    int br0, fe0;
    logic [7:0] b;
    br0 = br_cnt; fe0 = fe_cnt; b = 8'h1C;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(b[i]);
    tick(TO + 15);
    checks++; if (fe_cnt !== fe0 + 1) begin errors++; $display("FAIL timeout_err: got %0d pulses expected 1", fe_cnt - fe0); end
    checks++; if (br_cnt !== br0) begin errors++; $display("FAIL timeout_no_event: got %0d pulses expected 0", br_cnt - br0); end
    send_frame(8'h1C);
    checks++; if (key_down[9'h01C] !== 1'b1 || last_change !== 9'h01C) begin errors++; $display("FAIL timeout_recover: bit=%b last=%h expected 1/01c", key_down[9'h01C], last_change); end
  endtask

  task automatic test_pause;
    int br0;
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    br0 = br_cnt;
    for (int i = 0; i < 8; i++) send_frame(seq[i]);
    checks++; if (br_cnt !== br0) begin errors++; $display("FAIL pause_no_event: got %0d pulses expected 0", br_cnt - br0); end
    checks++; if (key_down[9'h014] !== 1'b0 || key_down[9'h077] !== 1'b0) begin errors++; $display("FAIL pause_map: 014=%b 077=%b expected 0/0", key_down[9'h014], key_down[9'h077]); end
    send_frame(8'h1C);
    checks++; if (br_cnt !== br0 + 1) begin errors++; $display("FAIL pause_then_1c_count: got %0d pulses expected 1", br_cnt - br0); end
    checks++; if (last_change !== 9'h01C) begin errors++; $display("FAIL pause_then_1c_last: got %h expected 01c", last_change); end
  endtask

  task automatic test_reset_mid;
    int br0;
    logic [7:0] b;
    b = 8'h1C;
    send_frame(8'h12);
    checks++; if (key_down[9'h012] !== 1'b1) begin errors++; $display("FAIL pre_reset_12: got %b expected 1", key_down[9'h012]); end
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(b[i]);
    rst = 1'b0;
    tick(3);
    checks++; if (key_down !== 512'd0) begin errors++; $display("FAIL mid_reset_map: popcount=%0d expected 0", $countones(key_down)); end
    checks++; if (last_change !== 9'h000 || been_ready !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL mid_reset_outs: last=%h br=%b fe=%b expected 000/0/0", last_change, been_ready, frame_err); end
    rst = 1'b1;
    tick(5);
    br0 = br_cnt;
    send_frame(8'h1C);
    checks++; if (key_down !== (512'd1 << 28)) begin errors++; $display("FAIL post_reset_map: bit 01c=%b popcount=%0d expected only 01c", key_down[28], $countones(key_down)); end
    checks++; if (br_cnt !== br0 + 1) begin errors++; $display("FAIL post_reset_count: got %0d pulses expected 1", br_cnt - br0); end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_typematic();
    test_ignore();
    test_break_unheld();
    test_parity();
    test_stop_err();
    test_start_glitch();
    test_timeout();
    test_pause();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3ms;
    errors++;
    $display("FAIL watchdog: simulation time limit reached before all tests finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Front-end of the keyboard path. Receives raw PS/2 device-to-host frames on the `ps2_clk`/`ps2_data` pins and decodes scan-code set 2 make/break sequences, including the E0 extended prefix. It maintains a 512-bit pressed-key map and reports each completed key event with a one-cycle strobe. Its outputs drive the `key_down`, `last_change` and `been_ready` inputs of the LED output generator and the mode controller.

## Interface
- `SYNC_STAGES`, 2: flops in each pin synchronizer; minimum 2.
- `TIMEOUT_CYC`, 20000: idle clk cycles inside a frame before the frame is abandoned (200 µs at 100 MHz).
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `ps2_clk` in 1: PS/2 clock pin, asynchronous to `clk`.
- `ps2_data` in 1: PS/2 data pin, asynchronous to `clk`.
- `key_down` out 512: bit {ext,code} is 1 while that key is held.
- `last_change` out 9: index {ext,code} of the most recent key event.
- `been_ready` out 1: one-cycle strobe; a key event was applied this cycle.
- `frame_err` out 1: one-cycle strobe on a parity, stop-bit or timeout error.

## Operation
- Pins pass through `SYNC_STAGES` flops. A falling edge is detected when the synchronized clock is 0 and its previous value was 1. Data is sampled on that edge.
- Frame receiver:
  - Frame format: start 0, 8 data bits LSB first, odd parity, stop 1. A 4-bit counter runs 0..10.
  - Start bit sampled as 1: discard it and stay at bit 0. No error is reported.
  - Parity or stop-bit failure: pulse `frame_err`, discard the byte, return the decoder FSM to IDLE.
  - Valid frame: produces an internal `byte_valid` and `byte` for one cycle.
- Timeout:
  - An idle counter runs while the bit counter is not 0 and clears on every falling edge.
  - When it reaches `TIMEOUT_CYC`: bit counter resets to 0, `frame_err` pulses, decoder FSM returns to IDLE.
  - A falling edge in the same cycle as the timeout wins: the edge is sampled normally and no timeout occurs.
- Decoder FSM, states IDLE, EXT, BRK, EXT_BRK, SKIP:
  - Prefix bytes: E0 moves IDLE→EXT. F0 moves IDLE→BRK and EXT→EXT_BRK.
  - E1 moves any state→SKIP, loads a skip counter with 7, and produces no event. Each following byte decrements the counter; at 0 the FSM returns to IDLE. This covers the Pause key.
  - Ignored bytes: AA, FA, FE, EE, 00, FF produce no event and leave the state unchanged.
  - Any other byte is code `c`, giving index `i` = {ext,c}, where ext=1 in EXT and EXT_BRK.
  - Make (IDLE, EXT): `key_down[i]` ← 1.
  - Break (BRK, EXT_BRK): `key_down[i]` ← 0.
  - On every make or break: `last_change` ← `i`, `been_ready` pulses, FSM returns to IDLE.
- Typematic repeat makes re-pulse `been_ready` each time, with `key_down` unchanged.
- Break of a key that is not held: the bit stays 0, and `been_ready` and `last_change` still update.

## Timing
- Reset values: `key_down` all 0, `last_change` 0, `been_ready` 0, `frame_err` 0. Bit counter, idle counter and skip counter are 0; FSM is IDLE.
- Reset mid-frame discards the partial frame. The next falling edge is treated as a start bit.
- `byte_valid` is high in cycle k+1, where k is the cycle the stop-bit edge is detected.
- `key_down`, `last_change` and `been_ready` all update in cycle k+2.
- `frame_err` is high in cycle k+1 for parity/stop errors. For timeouts it is high in the cycle after the counter reaches `TIMEOUT_CYC`.
- All outputs are registered. `been_ready` and `frame_err` never stay high longer than one cycle.
- Throughput: one byte per frame; no backpressure. `been_ready` pulses are at least 11 PS/2 bit periods apart.

## Structure
- `ps2_pkg` holds:
  - byte constants: E0, F0, E1 and the ignore list;
  - `KEY_IDX_W` = 9;
  - the decoder FSM state enum.
- Sub-module `ps2_rx_frame` contains the synchronizers, edge detect, bit counter, parity check and timeout. It outputs `byte`, `byte_valid` and `frame_err`.
- The top level holds the decoder FSM, skip counter and key map.

## Test plan
- Frame 1C (A make), then F0 1C: `key_down[0x01C]` is 1 after the first frame and `been_ready` pulses at k+2 with `last_change`=0x01C. After the break, the bit returns to 0 and `been_ready` pulses again.
- E0 75 (up arrow make), then E0 F0 75: `key_down[0x175]` goes 1, then 0. `last_change`=0x175 both times. Bit 0x075 is untouched.
- Frame 29 with the parity bit flipped: `frame_err` pulses once, no `been_ready`, `key_down` unchanged. A following good 29 sets `key_down[0x029]`.
- Drive 5 bits of a frame, then hold `ps2_clk` high for `TIMEOUT_CYC`+5 cycles: `frame_err` pulses. A following full 1C frame decodes correctly.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 1C: no events for the 8 Pause bytes. The final 1C gives exactly one `been_ready` with `last_change`=0x01C.
- Send 12, then assert `rst` halfway through a 1C frame, then release it: all outputs are 0, including `key_down[0x012]`. A following full 1C frame sets only `key_down[0x01C]`.
